// File: rtl/spi_reg_bank.sv
// Command decoder and register bank downstream of the SPI slave: word 0 of a frame
// is a command (rw + address), subsequent words are burst data with address auto-increment.
module spi_reg_bank #(
  parameter int                   WORD_SIZE = 16,
  parameter int                   ADDR_BITS = 4,
  parameter int                   NUM_WR    = 4,
  parameter int                   NUM_RO    = 4,
  parameter logic [WORD_SIZE-1:0] ID_WORD   = 16'hC0DE
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_sce,
  input  logic [WORD_SIZE-1:0]        i_wout,
  input  logic                        i_wstb,
  output logic [WORD_SIZE-1:0]        o_win,
  input  logic [NUM_RO*WORD_SIZE-1:0] i_stat,
  output logic [NUM_WR*WORD_SIZE-1:0] o_ctrl,
  output logic                        o_wr_stb,
  output logic [ADDR_BITS-1:0]        o_wr_addr
);

  typedef enum logic {CMD, DATA} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   rw_q, rw_d;
  logic [WORD_SIZE-1:0]   ctrl_q [NUM_WR];
  logic [WORD_SIZE-1:0]   ctrl_d [NUM_WR];
  logic [WORD_SIZE-1:0]   win_q, win_d;
  logic                   wr_stb_q, wr_stb_d;
  logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_BITS-1:0]   cmd_addr;
  logic [ADDR_BITS-1:0]   next_addr;

  // Read mux sees pre-write register values, so a same-cycle write never leaks into o_win.
  function automatic logic [WORD_SIZE-1:0] rd(input logic [ADDR_BITS-1:0] a);
    logic [WORD_SIZE-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < NUM_WR; k++)
      if (a == ADDR_BITS'(k)) v = ctrl_q[k];
    for (int unsigned k = 0; k < NUM_RO; k++)
      if (a == ADDR_BITS'(NUM_WR + k)) v = i_stat[k*WORD_SIZE +: WORD_SIZE];
    return v;
  endfunction

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    ctrl_d    = ctrl_q;
    win_d     = win_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    cmd_addr  = i_wout[ADDR_BITS-1:0];
    next_addr = addr_q + ADDR_BITS'(1);
    if (i_sce) begin
      state_d = CMD;
      win_d   = ID_WORD;
    end else if (i_wstb) begin
      if (state_q == CMD) begin
        rw_d    = i_wout[WORD_SIZE-1];
        addr_d  = cmd_addr;
        win_d   = rd(cmd_addr);
        state_d = DATA;
      end else begin
        if (!rw_q) begin
          for (int unsigned k = 0; k < NUM_WR; k++) begin
            if (addr_q == ADDR_BITS'(k)) begin
              ctrl_d[k] = i_wout;
              wr_stb_d  = 1'b1;
              wr_addr_d = addr_q;
            end
          end
        end
        addr_d = next_addr;
        win_d  = rd(next_addr);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= CMD;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      ctrl_q    <= '{default: '0};
      win_q     <= ID_WORD;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      ctrl_q    <= ctrl_d;
      win_q     <= win_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  always_comb begin
    o_ctrl = '0;
    for (int unsigned k = 0; k < NUM_WR; k++)
      o_ctrl[k*WORD_SIZE +: WORD_SIZE] = ctrl_q[k];
  end

  assign o_win     = win_q;
  assign o_wr_stb  = wr_stb_q;
  assign o_wr_addr = wr_addr_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: write/read bursts, RO/out-of-range writes,
// address wrap, frame abort and mid-burst reset, with hand-computed expectations.
module tb_spi_reg_bank;

  logic        clk;
  logic        rst_n;
  logic        sce;
  logic [15:0] wout;
  logic        wstb;
  logic [15:0] win;
  logic [63:0] stat;
  logic [63:0] ctrl;
  logic        wr_stb;
  logic [3:0]  wr_addr;

  int n_cmp;
  int n_bad;
  int n_stb;

  spi_reg_bank #(
    .WORD_SIZE(16),
    .ADDR_BITS(4),
    .NUM_WR(4),
    .NUM_RO(4),
    .ID_WORD(16'hC0DE)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_sce    (sce),
    .i_wout   (wout),
    .i_wstb   (wstb),
    .o_win    (win),
    .i_stat   (stat),
    .o_ctrl   (ctrl),
    .o_wr_stb (wr_stb),
    .o_wr_addr(wr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (wr_stb === 1'b1) n_stb++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the strobe has been sampled.
  task automatic word(input logic [15:0] w);
    wout = w;
    wstb = 1'b1;
    @(posedge clk); #1;
    wstb = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic new_frame();
    sce = 1'b1;
    idle(1);
    check("idle_win", {48'h0, win}, {48'h0, 16'hC0DE});
    sce = 1'b0;
    idle(1);
  endtask

  function automatic logic [15:0] reg_of(input int k);
    return ctrl[k*16 +: 16];
  endfunction

  initial begin
    n_cmp = 0; n_bad = 0; n_stb = 0;
    rst_n = 1'b0; sce = 1'b1; wout = '0; wstb = 1'b0;
    stat = {16'hD00D, 16'hF00D, 16'hCAFE, 16'hBEEF};
    @(posedge clk); #1;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    check("rst_win", {48'h0, win}, {48'h0, 16'hC0DE});
    check("rst_ctrl", ctrl, 64'h0);
    check("rst_stb", {63'h0, wr_stb}, 64'h0);
    check("rst_waddr", {60'h0, wr_addr}, 64'h0);
    check("idle_nstb", n_stb, 0);

    // write burst to 1,2
    sce = 1'b0; idle(1);
    word(16'h0001);
    check("wb_cmd_win", {48'h0, win}, 64'h0);
    check("wb_cmd_stb", {63'h0, wr_stb}, 64'h0);
    word(16'h1234);
    check("wb_d0_stb", {63'h0, wr_stb}, 64'h1);
    check("wb_d0_addr", {60'h0, wr_addr}, 64'h1);
    check("wb_d0_ctrl1", {48'h0, reg_of(1)}, {48'h0, 16'h1234});
    word(16'h5678);
    check("wb_d1_stb", {63'h0, wr_stb}, 64'h1);
    check("wb_d1_addr", {60'h0, wr_addr}, 64'h2);
    check("wb_ctrl", ctrl, 64'h0000_5678_1234_0000);
    idle(1);
    check("wb_stb_pulse", {63'h0, wr_stb}, 64'h0);

    // status read with snapshot semantics
    new_frame();
    word(16'h8004);
    check("rd_beef", {48'h0, win}, {48'h0, 16'hBEEF});
    check("rd_nostb", {63'h0, wr_stb}, 64'h0);
    stat[15:0] = 16'h1111;
    idle(2);
    check("rd_snapshot", {48'h0, win}, {48'h0, 16'hBEEF});
    word(16'hAAAA);
    check("rd_next_win", {48'h0, win}, {48'h0, 16'hCAFE});
    check("rd_discard", ctrl, 64'h0000_5678_1234_0000);
    stat[15:0] = 16'hBEEF;

    // read control regs
    new_frame();
    word(16'h8001);
    check("rc_1", {48'h0, win}, {48'h0, 16'h1234});
    word(16'h0000);
    check("rc_2", {48'h0, win}, {48'h0, 16'h5678});

    // last status slot, then past end of map
    new_frame();
    word(16'h8007);
    check("rs_7", {48'h0, win}, {48'h0, 16'hD00D});
    word(16'h0000);
    check("rs_8_zero", {48'h0, win}, 64'h0);

    // write to RO address is ignored
    new_frame();
    word(16'h0005);
    word(16'hFFFF);
    check("ro_nostb", {63'h0, wr_stb}, 64'h0);
    check("ro_ctrl", ctrl, 64'h0000_5678_1234_0000);
    check("ro_win", {48'h0, win}, {48'h0, 16'hF00D});

    // ctrl0 write, then last writable address and first non-writable
    new_frame();
    word(16'h0000);
    word(16'h0A0A);
    check("w0_addr", {60'h0, wr_addr}, 64'h0);
    check("w0_stb", {63'h0, wr_stb}, 64'h1);
    new_frame();
    word(16'h0003);
    word(16'h3333);
    check("w3_stb", {63'h0, wr_stb}, 64'h1);
    check("w3_addr", {60'h0, wr_addr}, 64'h3);
    word(16'h4444);
    check("w4_nostb", {63'h0, wr_stb}, 64'h0);
    check("w34_ctrl", ctrl, 64'h3333_5678_1234_0A0A);

    // read wrap 15 -> 0 -> 1
    new_frame();
    word(16'h800F);
    check("wrap_rd15", {48'h0, win}, 64'h0);
    word(16'h0000);
    check("wrap_rd0", {48'h0, win}, {48'h0, 16'h0A0A});
    word(16'h0000);
    check("wrap_rd1", {48'h0, win}, {48'h0, 16'h1234});
    word(16'h0000);
    check("wrap_rd2", {48'h0, win}, {48'h0, 16'h5678});

    // write wrap: addr 15 ignored, then addr 0 written
    new_frame();
    word(16'h000F);
    word(16'h1111);
    check("wwrap_15_nostb", {63'h0, wr_stb}, 64'h0);
    word(16'h2222);
    check("wwrap_0_stb", {63'h0, wr_stb}, 64'h1);
    check("wwrap_0_addr", {60'h0, wr_addr}, 64'h0);
    check("wwrap_ctrl", ctrl, 64'h3333_5678_1234_2222);

    // abort after command word; partial word commits nothing
    new_frame();
    word(16'h0001);
    wout = 16'hDEAD;
    idle(2);
    sce = 1'b1;
    idle(1);
    check("abort_win", {48'h0, win}, {48'h0, 16'hC0DE});
    sce = 1'b0;
    idle(1);
    check("abort_ctrl", ctrl, 64'h3333_5678_1234_2222);
    word(16'h8002);
    check("abort_cmd", {48'h0, win}, {48'h0, 16'h5678});
    word(16'h9999);
    check("abort_rd_discard", ctrl, 64'h3333_5678_1234_2222);
    check("abort_nostb", {63'h0, wr_stb}, 64'h0);

    // reset mid-burst
    new_frame();
    word(16'h0001);
    word(16'h7777);
    check("mr_stb", {63'h0, wr_stb}, 64'h1);
    rst_n = 1'b0;
    idle(1);
    check("mr_win", {48'h0, win}, {48'h0, 16'hC0DE});
    check("mr_ctrl", ctrl, 64'h0);
    check("mr_stb0", {63'h0, wr_stb}, 64'h0);
    check("mr_waddr", {60'h0, wr_addr}, 64'h0);
    rst_n = 1'b1;
    idle(1);
    word(16'h8002);
    check("mr_cmd_after", {48'h0, win}, 64'h0);
    word(16'h0000);
    check("mr_rd3", {48'h0, win}, 64'h0);
    idle(2);

    check("total_stb", n_stb, 6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
